// File: rtl/stimulus_sweeper_if.sv
// Sweeper-side bundle: control, stimulus out, responses in,
// and the registered sweep summary.
interface stimulus_sweeper_if #(
  parameter int WIDTH = 2,
  parameter int NRESP = 2
);
  logic             start;
  logic             abort;
  logic [NRESP-1:0] resp_dut;
  logic [NRESP-1:0] resp_ref;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_count;
  logic [WIDTH-1:0] first_fail_vec;
  logic             first_fail_vld;

  modport master (
    input  start, abort, resp_dut, resp_ref,
    output stim, busy, done, pass,
    output err_count, first_fail_vec, first_fail_vld
  );

  modport slave (
    output start, abort, resp_dut, resp_ref,
    input  stim, busy, done, pass,
    input  err_count, first_fail_vec, first_fail_vld
  );
endinterface

// File: rtl/stimulus_sweeper.sv
// Sweeps stim over 0..2^WIDTH-1, holds each vector SETTLE+1 cycles,
// compares responses at the closing edge and reports a summary.
module stimulus_sweeper #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int NRESP  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  stimulus_sweeper_if.master  sw
);

  localparam int HW =
    (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(SETTLE);
  localparam logic [WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [HW-1:0]    holdCnt;
  logic [HW-1:0]    holdNxt;
  logic [WIDTH-1:0] stimQ;
  logic [WIDTH-1:0] stimNxt;
  logic [WIDTH-1:0] ffVec;
  logic [WIDTH-1:0] ffVecNxt;
  logic [WIDTH:0]   errCnt;
  logic [WIDTH:0]   errNxt;
  logic             busyQ;
  logic             busyNxt;
  logic             doneQ;
  logic             doneNxt;
  logic             passQ;
  logic             passNxt;
  logic             ffVld;
  logic             ffVldNxt;
  logic             sampleNow;
  logic             mismatch;

  assign sampleNow = (holdCnt == HOLD_MAX);
  assign mismatch  = (sw.resp_dut != sw.resp_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      holdCnt <= '0;
      stimQ   <= '0;
      ffVec   <= '0;
      errCnt  <= '0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      passQ   <= 1'b0;
      ffVld   <= 1'b0;
    end else begin
      state   <= stateNxt;
      holdCnt <= holdNxt;
      stimQ   <= stimNxt;
      ffVec   <= ffVecNxt;
      errCnt  <= errNxt;
      busyQ   <= busyNxt;
      doneQ   <= doneNxt;
      passQ   <= passNxt;
      ffVld   <= ffVldNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    holdNxt  = holdCnt;
    stimNxt  = stimQ;
    ffVecNxt = ffVec;
    errNxt   = errCnt;
    busyNxt  = busyQ;
    doneNxt  = doneQ;
    passNxt  = passQ;
    ffVldNxt = ffVld;
    unique case (state)
      IDLE, DONE: begin
        if (sw.start) begin
          stateNxt = RUN;
          holdNxt  = '0;
          stimNxt  = '0;
          ffVecNxt = '0;
          errNxt   = '0;
          busyNxt  = 1'b1;
          doneNxt  = 1'b0;
          passNxt  = 1'b0;
          ffVldNxt = 1'b0;
        end
      end
      RUN: begin
        if (sw.abort) begin
          // results so far are kept; the pending sample is dropped
          stateNxt = IDLE;
          holdNxt  = '0;
          stimNxt  = '0;
          busyNxt  = 1'b0;
          doneNxt  = 1'b0;
        end else if (!sampleNow) begin
          holdNxt = holdCnt + 1'b1;
        end else begin
          holdNxt = '0;
          if (mismatch) begin
            errNxt = errCnt + 1'b1;
            if (!ffVld) begin
              ffVecNxt = stimQ;
              ffVldNxt = 1'b1;
            end
          end
          if (stimQ == LAST) begin
            stateNxt = DONE;
            stimNxt  = '0;
            busyNxt  = 1'b0;
            doneNxt  = 1'b1;
            passNxt  = (errNxt == '0);
          end else begin
            stimNxt = stimQ + 1'b1;
          end
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  assign sw.stim           = stimQ;
  assign sw.busy           = busyQ;
  assign sw.done           = doneQ;
  assign sw.pass           = passQ;
  assign sw.err_count      = errCnt;
  assign sw.first_fail_vec = ffVec;
  assign sw.first_fail_vld = ffVld;

endmodule

// File: tb/tb_stimulus_sweeper.sv
// Directed bench: two sweeper configurations driven
// through their interfaces with hand-computed expectations.
module tb_stimulus_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  stimulus_sweeper_if #(.WIDTH(2), .NRESP(2)) sw ();
  stimulus_sweeper_if #(.WIDTH(3), .NRESP(2)) sw6 ();

  stimulus_sweeper #(.WIDTH(2), .SETTLE(1), .NRESP(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  stimulus_sweeper #(.WIDTH(3), .SETTLE(2), .NRESP(2)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw6)
  );

  // golden: {AND, XOR}; mode 1 corrupts the XOR bit at stim=2
  assign sw.resp_ref = {sw.stim[1] & sw.stim[0],
                        sw.stim[1] ^ sw.stim[0]};
  assign sw.resp_dut = sw.resp_ref ^
    ((mode == 1 && sw.stim == 2'd2) ? 2'b01 : 2'b00);

  assign sw6.resp_ref = {^sw6.stim, &sw6.stim};
  assign sw6.resp_dut = ~sw6.resp_ref;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sw.abort  = 1'b0;
    sw.start  = 1'b0;
    sw6.start = 1'b0;
    sw6.abort = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw.start  = 1'($urandom);
      sw.abort  = 1'($urandom);
      sw6.start = 1'($urandom);
      tick();
      checks++;
      if ({sw.stim, sw.busy, sw.done, sw.pass, sw.err_count,
           sw.first_fail_vec, sw.first_fail_vld} !== 11'd0) begin
        errors++;
        $display("FAIL reset_outs cyc=%0d got stim=%0d busy=%0b done=%0b err=%0d want all 0",
                 i, sw.stim, sw.busy, sw.done, sw.err_count);
      end
      checks++;
      if ({sw6.stim, sw6.busy, sw6.done, sw6.pass, sw6.err_count,
           sw6.first_fail_vec, sw6.first_fail_vld} !== 14'd0) begin
        errors++;
        $display("FAIL reset_outs6 cyc=%0d got busy=%0b err=%0d want all 0",
                 i, sw6.busy, sw6.err_count);
      end
    end
    sw.start  = 1'b0;
    sw.abort  = 1'b0;
    sw6.start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (sw.busy !== 1'b0 || sw.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%0b done=%0b want 0 0",
               sw.busy, sw.done);
    end
  endtask

  task automatic test_clean_sweep();
    mode = 0;
    sw.start = 1'b1;
    tick();
    sw.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sw.stim !== 2'(i >> 1) || sw.busy !== 1'b1 ||
          sw.done !== 1'b0) begin
        errors++;
        $display("FAIL clean_step i=%0d got stim=%0d busy=%0b done=%0b want stim=%0d busy=1 done=0",
                 i, sw.stim, sw.busy, sw.done, i >> 1);
      end
      tick();
    end
    checks++;
    if (sw.done !== 1'b1 || sw.busy !== 1'b0 || sw.pass !== 1'b1) begin
      errors++;
      $display("FAIL clean_done got done=%0b busy=%0b pass=%0b want 1 0 1",
               sw.done, sw.busy, sw.pass);
    end
    checks++;
    if (sw.err_count !== 3'd0 || sw.first_fail_vld !== 1'b0 ||
        sw.stim !== 2'd0) begin
      errors++;
      $display("FAIL clean_result got err=%0d vld=%0b stim=%0d want 0 0 0",
               sw.err_count, sw.first_fail_vld, sw.stim);
    end
  endtask

  task automatic test_single_fault();
    mode = 1;
    sw.start = 1'b1;
    tick();
    sw.start = 1'b0;
    checks++;
    if (sw.err_count !== 3'd0 || sw.done !== 1'b0 || sw.busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_start got err=%0d done=%0b busy=%0b want 0 0 1",
               sw.err_count, sw.done, sw.busy);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (sw.done !== 1'b0) begin
      errors++;
      $display("FAIL fault_early_done got done=%0b want 0", sw.done);
    end
    tick();
    checks++;
    if (sw.done !== 1'b1 || sw.pass !== 1'b0 || sw.err_count !== 3'd1) begin
      errors++;
      $display("FAIL fault_done got done=%0b pass=%0b err=%0d want 1 0 1",
               sw.done, sw.pass, sw.err_count);
    end
    checks++;
    if (sw.first_fail_vec !== 2'd2 || sw.first_fail_vld !== 1'b1) begin
      errors++;
      $display("FAIL fault_first got vec=%0d vld=%0b want 2 1",
               sw.first_fail_vec, sw.first_fail_vld);
    end
    tick();
    checks++;
    if (sw.done !== 1'b1 || sw.err_count !== 3'd1) begin
      errors++;
      $display("FAIL fault_hold got done=%0b err=%0d want 1 1",
               sw.done, sw.err_count);
    end
  endtask

  task automatic test_start_then_abort();
    mode = 1;
    sw.start = 1'b1;
    tick();
    sw.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (sw.stim !== 2'(i >> 1) || sw.busy !== 1'b1) begin
        errors++;
        $display("FAIL run_step i=%0d got stim=%0d busy=%0b want stim=%0d busy=1",
                 i, sw.stim, sw.busy, i >> 1);
      end
      if (i == 2) sw.start = 1'b1;
      if (i == 3) sw.start = 1'b0;
      if (i == 5) sw.abort = 1'b1;
      tick();
    end
    sw.abort = 1'b0;
    checks++;
    if (sw.busy !== 1'b0 || sw.done !== 1'b0 || sw.stim !== 2'd0) begin
      errors++;
      $display("FAIL abort_outs got busy=%0b done=%0b stim=%0d want 0 0 0",
               sw.busy, sw.done, sw.stim);
    end
    checks++;
    if (sw.err_count !== 3'd0 || sw.first_fail_vld !== 1'b0) begin
      errors++;
      $display("FAIL abort_discard got err=%0d vld=%0b want 0 0",
               sw.err_count, sw.first_fail_vld);
    end
    sw.abort = 1'b1;
    tick();
    sw.abort = 1'b0;
    checks++;
    if (sw.busy !== 1'b0 || sw.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%0b done=%0b want 0 0",
               sw.busy, sw.done);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0;
    sw.start = 1'b1;
    tick();
    sw.start = 1'b0;
    tick();
    tick();
    checks++;
    if (sw.stim !== 2'd1 || sw.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got stim=%0d busy=%0b want 1 1",
               sw.stim, sw.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw.stim, sw.busy, sw.done, sw.pass, sw.err_count,
         sw.first_fail_vec, sw.first_fail_vld} !== 11'd0) begin
      errors++;
      $display("FAIL midrst_async got stim=%0d busy=%0b done=%0b want all 0",
               sw.stim, sw.busy, sw.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (sw.done !== 1'b0 || sw.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone got done=%0b busy=%0b want 0 0",
               sw.done, sw.busy);
    end
    test_clean_sweep();
  endtask

  task automatic test_wide_all_fail();
    sw6.start = 1'b1;
    tick();
    sw6.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (sw6.stim !== 3'(i / 3) || sw6.busy !== 1'b1 ||
          sw6.done !== 1'b0) begin
        errors++;
        $display("FAIL wide_step i=%0d got stim=%0d busy=%0b done=%0b want stim=%0d busy=1 done=0",
                 i, sw6.stim, sw6.busy, sw6.done, i / 3);
      end
      tick();
    end
    checks++;
    if (sw6.done !== 1'b1 || sw6.busy !== 1'b0 || sw6.pass !== 1'b0 ||
        sw6.stim !== 3'd0) begin
      errors++;
      $display("FAIL wide_done got done=%0b busy=%0b pass=%0b stim=%0d want 1 0 0 0",
               sw6.done, sw6.busy, sw6.pass, sw6.stim);
    end
    checks++;
    if (sw6.err_count !== 4'd8 || sw6.first_fail_vec !== 3'd0 ||
        sw6.first_fail_vld !== 1'b1) begin
      errors++;
      $display("FAIL wide_result got err=%0d vec=%0d vld=%0b want 8 0 1",
               sw6.err_count, sw6.first_fail_vec, sw6.first_fail_vld);
    end
    sw6.start = 1'b1;
    tick();
    sw6.start = 1'b0;
    checks++;
    if (sw6.err_count !== 4'd0 || sw6.first_fail_vld !== 1'b0 ||
        sw6.done !== 1'b0 || sw6.busy !== 1'b1 || sw6.pass !== 1'b0) begin
      errors++;
      $display("FAIL wide_restart got err=%0d vld=%0b done=%0b busy=%0b pass=%0b want 0 0 0 1 0",
               sw6.err_count, sw6.first_fail_vld, sw6.done, sw6.busy, sw6.pass);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_start_then_abort();
    test_reset_mid();
    test_wide_all_fail();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
